// File: rtl/trig_link_pkg.sv
// Shared types and default timing for the trigger-link TX reset controller.
// State encodings are visible on state_o and must stay stable.
package trig_link_pkg;

   localparam int N_LINKS = 4;

   localparam int DEF_PWRUP_CYCLES  = 1023;
   localparam int DEF_RST_WIDTH     = 16;
   localparam int DEF_DONE_TIMEOUT  = 4095;
   localparam int DEF_STABLE_CYCLES = 63;
   localparam int DEF_MAX_RETRIES   = 15;

   typedef enum logic [2:0] {
      ST_PWRUP     = 3'd0,
      ST_ASSERT    = 3'd1,
      ST_WAIT_DONE = 3'd2,
      ST_READY     = 3'd3,
      ST_RETRY     = 3'd4,
      ST_FAILED    = 3'd5
   } tx_rst_state_e;

endpackage

// File: rtl/synchronizer.sv
// Multi-flop synchronizer bringing one asynchronous level into the local clock domain.
module synchronizer #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_sync
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_async};
      end
   end

   assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/trig_link_tx_reset_ctrl.sv
// Trigger-link MGT TX reset sequencer: power-up delay, soft-reset pulse, lane-done qualification,
// timeout and bounded retry. Define TRIG_LINK_AUTO_RECOVER_EN to re-reset automatically on done loss in READY.
module trig_link_tx_reset_ctrl
   import trig_link_pkg::*;
#(
   parameter int PWRUP_CYCLES  = DEF_PWRUP_CYCLES,
   parameter int RST_WIDTH     = DEF_RST_WIDTH,
   parameter int DONE_TIMEOUT  = DEF_DONE_TIMEOUT,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
   input  logic               clock_40,
   input  logic               reset_i,
   input  logic [N_LINKS-1:0] tx_fsm_reset_done_i,
   input  logic [N_LINKS-1:0] link_mask_i,
   input  logic               force_reset_i,
   output logic               mgt_reset_o,
   output logic               ready_o,
   output logic               link_err_o,
   output logic [2:0]         state_o,
   output logic [3:0]         retry_cnt_o
);

   localparam int PW_W = $clog2(PWRUP_CYCLES + 1);
   localparam int RW_W = $clog2(RST_WIDTH + 1);
   localparam int TO_W = $clog2(DONE_TIMEOUT + 1);
   localparam int SB_W = $clog2(STABLE_CYCLES + 1);

   // "LAST" is the count seen on the final cycle a state may occupy, so each
   // timed state lasts exactly its parameter in cycles.
   localparam logic [PW_W-1:0] PW_LAST = PW_W'(PWRUP_CYCLES - 1);
   localparam logic [PW_W-1:0] PW_TERM = PW_W'(PWRUP_CYCLES);
   localparam logic [RW_W-1:0] RW_LAST = RW_W'(RST_WIDTH - 1);
   localparam logic [RW_W-1:0] RW_TERM = RW_W'(RST_WIDTH);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(DONE_TIMEOUT - 1);
   localparam logic [TO_W-1:0] TO_TERM = TO_W'(DONE_TIMEOUT);
   localparam logic [SB_W-1:0] SB_LAST = SB_W'(STABLE_CYCLES - 1);
   localparam logic [SB_W-1:0] SB_TERM = SB_W'(STABLE_CYCLES);
   localparam logic [3:0]      RETRY_MAX = 4'(MAX_RETRIES);

   tx_rst_state_e     r_state;
   tx_rst_state_e     w_state_next;
   logic [PW_W-1:0]   r_pwrup_cnt;
   logic [RW_W-1:0]   r_rst_cnt;
   logic [TO_W-1:0]   r_timer;
   logic [SB_W-1:0]   r_stable_cnt;
   logic [3:0]        r_retry_cnt;
   logic              r_mgt_reset;
   logic              r_ready;
   logic              r_link_err;
   logic [N_LINKS-1:0] w_sync_done;
   logic              w_done_ok;
   logic              w_force;
   logic              w_restart;

   for (genvar g = 0; g < N_LINKS; g++) begin : g_lane_sync
      synchronizer #(.STAGES(2)) u_sync (
         .i_clk   (clock_40),
         .i_rst   (reset_i),
         .i_async (tx_fsm_reset_done_i[g]),
         .o_sync  (w_sync_done[g])
      );
   end

   assign w_done_ok = &(w_sync_done | link_mask_i);
   assign w_force   = force_reset_i && (r_state != ST_PWRUP);
   // Any state change, or a forced restart of ASSERT, starts the per-state counters afresh.
   assign w_restart = w_force || (w_state_next != r_state);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_PWRUP: begin
            if (r_pwrup_cnt == PW_LAST) w_state_next = ST_ASSERT;
         end
         ST_ASSERT: begin
            if (r_rst_cnt == RW_LAST) w_state_next = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (w_done_ok && (r_stable_cnt == SB_LAST)) begin
               w_state_next = ST_READY;
            end else if (r_timer == TO_LAST) begin
               w_state_next = ST_RETRY;
            end
         end
         ST_READY: begin
            if (!w_done_ok) begin
`ifdef TRIG_LINK_AUTO_RECOVER_EN
               w_state_next = ST_RETRY;
`else
               w_state_next = ST_FAILED;
`endif
            end
         end
         ST_RETRY: begin
            w_state_next = (r_retry_cnt == RETRY_MAX) ? ST_FAILED : ST_ASSERT;
         end
         ST_FAILED: begin
            w_state_next = ST_FAILED;
         end
         default: begin
            w_state_next = ST_PWRUP;
         end
      endcase
      if (w_force) w_state_next = ST_ASSERT;
   end

   always_ff @(posedge clock_40) begin
      if (reset_i) begin
         r_state      <= ST_PWRUP;
         r_pwrup_cnt  <= '0;
         r_rst_cnt    <= '0;
         r_timer      <= '0;
         r_stable_cnt <= '0;
         r_retry_cnt  <= '0;
         r_mgt_reset  <= 1'b0;
         r_ready      <= 1'b0;
         r_link_err   <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_mgt_reset <= (w_state_next == ST_ASSERT);
         r_ready     <= (w_state_next == ST_READY);
         r_link_err  <= (w_state_next == ST_FAILED);

         if (w_restart) begin
            r_pwrup_cnt  <= '0;
            r_rst_cnt    <= '0;
            r_timer      <= '0;
            r_stable_cnt <= '0;
         end else begin
            if ((r_state == ST_PWRUP) && (r_pwrup_cnt != PW_TERM)) begin
               r_pwrup_cnt <= r_pwrup_cnt + PW_W'(1);
            end
            if ((r_state == ST_ASSERT) && (r_rst_cnt != RW_TERM)) begin
               r_rst_cnt <= r_rst_cnt + RW_W'(1);
            end
            if (r_state == ST_WAIT_DONE) begin
               if (r_timer != TO_TERM) r_timer <= r_timer + TO_W'(1);
               if (!w_done_ok) begin
                  r_stable_cnt <= '0;
               end else if (r_stable_cnt != SB_TERM) begin
                  r_stable_cnt <= r_stable_cnt + SB_W'(1);
               end
            end
         end

         if (w_force || ((r_state == ST_WAIT_DONE) && (w_state_next == ST_READY))) begin
            r_retry_cnt <= '0;
         end else if ((r_state == ST_RETRY) && (r_retry_cnt != RETRY_MAX)) begin
            r_retry_cnt <= r_retry_cnt + 4'd1;
         end
      end
   end

   assign mgt_reset_o = r_mgt_reset;
   assign ready_o     = r_ready;
   assign link_err_o  = r_link_err;
   assign state_o     = r_state;
   assign retry_cnt_o = r_retry_cnt;

endmodule

// File: doc/trig_link_tx_reset_ctrl.md
Name: trig_link_tx_reset_ctrl

Overview:
Sequences reset and bring-up of the 4-lane trigger-link MGT transmitter.
- Waits a power-up delay, then pulses the MGT soft TX reset.
- Waits for all unmasked lanes to report tx_fsm_reset_done, holds off until they are stable, then asserts ready. The frame builder uses ready to leave the idle-comma (FFBC) state.
- Handles timeouts, loss-of-done and bounded retries; sits between the TTC/slow-control reset and the link wrapper.

Parameters:
PWRUP_CYCLES, 1023, clock_40 cycles from reset release to first MGT reset.
RST_WIDTH, 16, cycles mgt_reset_o is held high per attempt.
DONE_TIMEOUT, 4095, max cycles waiting for all-done before retry.
STABLE_CYCLES, 63, consecutive all-done cycles required before ready.
MAX_RETRIES, 15, failed attempts tolerated before FAILED state.

Ports:
clock_40  in  1  single clock for all logic.
reset_i  in  1  synchronous, active-high reset.
tx_fsm_reset_done_i  in  4  per-lane MGT reset-done; asynchronous, synchronized internally.
link_mask_i  in  4  1 = lane ignored for done checks; static outside READY.
force_reset_i  in  1  single-cycle request for a new reset sequence.
mgt_reset_o  out  1  MGT soft TX reset.
ready_o  out  1  link usable; gates the frame builder.
link_err_o  out  1  retries exhausted.
state_o  out  3  current FSM state encoding.
retry_cnt_o  out  4  attempts since last READY; saturates at 15.

Behaviour:
- Reset values: state PWRUP, all counters 0, mgt_reset_o=0, ready_o=0, link_err_o=0, retry_cnt_o=0.
- reset_i mid-operation returns to PWRUP from any state on the next edge.
- All outputs are registered.
- done_ok = AND over lanes of (sync_done | link_mask_i), where sync_done is the 2-flop synchronized tx_fsm_reset_done_i (2-cycle latency).
- If link_mask_i = 4'hF, done_ok = 1.

States:
- PWRUP (0): count to PWRUP_CYCLES, then go to ASSERT.
- ASSERT (1): mgt_reset_o=1 for exactly RST_WIDTH cycles, then go to WAIT_DONE with the timer cleared.
- WAIT_DONE (2):
  - Timer increments; stable counter increments while done_ok and clears when !done_ok.
  - Stable counter reaching STABLE_CYCLES -> READY, with retry_cnt cleared.
  - Timer reaching DONE_TIMEOUT -> RETRY.
  - If both occur on the same cycle, READY wins.
- READY (3):
  - ready_o=1 in the same cycle the state register equals READY.
  - done_ok falling -> ready_o=0 on the next edge; next state per the optional feature.
- RETRY (4):
  - retry_cnt increments (saturating).
  - If retry_cnt was already MAX_RETRIES -> FAILED; else -> ASSERT.
- FAILED (5): link_err_o=1, mgt_reset_o=0, ready_o=0. Exit only via reset_i or force_reset_i.

force_reset_i:
- In any state except PWRUP: go to ASSERT next cycle, ready_o drops, retry_cnt cleared, link_err_o cleared.
- Ignored in PWRUP.
- force_reset_i together with reset_i: reset_i wins.
- force_reset_i in ASSERT: the RST_WIDTH count restarts.

Counters:
- Counter widths are $clog2(param+1).
- Counters never wrap; they hold at their terminal value until a state change.

Optional Feature:
Macro TRIG_LINK_AUTO_RECOVER_EN.
- Defined: done_ok loss in READY -> RETRY, i.e. automatic re-reset with the retry budget applied.
- Undefined: done_ok loss in READY -> FAILED immediately; software must pulse force_reset_i.
- Port list is identical in both builds.

Decomposition:
- Shared package trig_link_pkg holds the state enum localparams, default timing constants, and the lane count N_LINKS=4.
- One natural sub-module: the codebase `synchronizer`, instantiated per lane for tx_fsm_reset_done_i.
- FSM and counters live in the top module.

Test Plan:
1. Power-up:
   - Stimulus: release reset_i; raise all done lanes 100 cycles after mgt_reset_o falls.
   - Required: mgt_reset_o rises at cycle 1023 and is high for 16 cycles; ready_o rises 2+63 cycles after done, i.e. within 66 cycles including output registration.
2. Timeout/retry:
   - Stimulus: hold lane 2 done=0.
   - Required: mgt_reset_o re-pulses every ~4095+16+2 cycles; retry_cnt_o counts 1..15; after the 16th timeout link_err_o=1, state_o=5, no further pulses.
3. Masking:
   - Stimulus: same as scenario 2 with link_mask_i=4'b0100.
   - Required: ready_o=1 after the first attempt; retry_cnt_o=0.
4. Loss of done:
   - Stimulus: in READY drop lane 0 done.
   - Required: ready_o=0 within 3 cycles.
     - With TRIG_LINK_AUTO_RECOVER_EN: state goes RETRY then ASSERT, mgt_reset_o pulses.
     - Without it: state_o=5, link_err_o=1.
5. force_reset_i:
   - Stimulus: pulse in FAILED; and pulse mid-ASSERT at width count 8.
   - Required: from FAILED, link_err_o clears and a 16-cycle reset pulse follows; mid-ASSERT, the pulse lasts 8+16 cycles total.
6. Reset mid-sequence:
   - Stimulus: reset_i during WAIT_DONE.
   - Required: next cycle all outputs are at reset values; the full 1023-cycle PWRUP delay repeats.
